mem_arbiter: RTL and testbench

Shares a single-ported instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads and stores). Requests are arbitrated and latched, and exactly one transaction is in flight at a time. Each response is routed back to the requester that owns the transaction. Sits between the two pipeline stages and the memory model/controller.

---
 rtl/mem_arbiter_pkg.sv | 8 +
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arb_starve_cnt.sv | 19 +
 rtl/mem_arbiter.sv | 70 +++++++
 tb/tb_mem_arbiter.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, owner and state enums for the IF/MEM memory arbiter
package mem_arbiter_pkg;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_STARVE_LIMIT = 4;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
  typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IF client, MEM client and memory-side signals of the arbiter
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // pipeline stages plus memory model
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
  // the arbiter itself
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_starve_cnt.sv
// mem_arb_starve_cnt: counts consecutive IF arbitration losses and forces an IF win at the limit
module mem_arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb,
  input  logic if_req,
  input  logic dm_win,
  output logic force_if
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  assign force_if = cnt >= CW'(LIMIT);
  // clear on an IF win, count an IF loss, saturate once the limit is reached
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt <= '0;
    else if (arb) cnt <= !dm_win ? '0 : (if_req && !force_if) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-transaction-at-a-time sharing of a single-ported memory between IF and MEM;
// MEM_ARB_STARVE_GUARD_EN adds a starvation guard that forces IF to win after STARVE_LIMIT losses
module mem_arbiter
  import mem_arbiter_pkg::*;
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
)
`endif
(
  input logic           clk_i,
  input logic           rst_i,
  mem_arbiter_if.slave  bus
);
  arb_state_t state;
  owner_t     owner;
  logic       arb;
  logic       dm_win;
  logic       force_if;
  assign arb    = state == IDLE && (bus.if_req || bus.dm_req);
  assign dm_win = bus.dm_req && !(force_if && bus.if_req);
`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .arb      (arb),
    .if_req   (bus.if_req),
    .dm_win   (dm_win),
    .force_if (force_if)
  );
`else
  assign force_if = 1'b0;
`endif
  // latch the winner in IDLE, present it from registers in REQ, wait for the response in RESP
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else
      case (state)
        IDLE:
          if (arb) begin
            state         <= REQ;
            owner         <= dm_win ? OWN_DM : OWN_IF;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= dm_win && bus.dm_we;
            bus.mem_addr  <= dm_win ? bus.dm_addr : bus.if_addr;
            bus.mem_wdata <= bus.dm_wdata;
          end
        REQ:
          if (bus.mem_gnt) begin
            state       <= RESP;
            bus.mem_req <= 1'b0;
          end
        RESP:
          if (bus.mem_rvalid) state <= IDLE;
        default:
          state <= IDLE;
      endcase
  assign bus.if_gnt    = state == REQ && owner == OWN_IF && bus.mem_gnt;
  assign bus.dm_gnt    = state == REQ && owner == OWN_DM && bus.mem_gnt;
  assign bus.if_rvalid = state == RESP && owner == OWN_IF && bus.mem_rvalid;
  assign bus.dm_rvalid = state == RESP && owner == OWN_DM && bus.mem_rvalid;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized clients and memory checked against a transaction-level model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;
  mem_arbiter_if bus ();
  mem_arbiter dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  typedef struct {
    bit          dm;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;
  txn_t        cur;
  bit          live;
  bit          accepted;
  int          losses;
  int          vectors = 0;
  int          errors = 0;
  int unsigned p_if, p_dm, p_gnt, p_rv;
  bit          if_done, dm_done;
  int          if_gnts, dm_gnts;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SAT_IF = 4;
  localparam int SAT_DM = 16;
`else
  localparam int SAT_IF = 0;
  localparam int SAT_DM = 20;
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic body();
    bit starved;
    if (!bus.if_req || if_done) begin
      bus.if_req  = $urandom_range(99) < p_if;
      bus.if_addr = 16'($urandom);
    end
    if (!bus.dm_req || dm_done) begin
      bus.dm_req   = $urandom_range(99) < p_dm;
      bus.dm_we    = 1'($urandom);
      bus.dm_addr  = 16'($urandom);
      bus.dm_wdata = 16'($urandom);
    end
    bus.mem_gnt    = $urandom_range(99) < p_gnt;
    bus.mem_rvalid = $urandom_range(99) < p_rv;
    bus.mem_rdata  = 16'($urandom);
    #1;
    chk("mem_req", 32'(bus.mem_req), 32'(live && !accepted));
    if (live && !accepted) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(cur.addr));
      chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
      if (cur.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(cur.wdata));
    end
    chk("if_gnt", 32'(bus.if_gnt), 32'(live && !accepted && !cur.dm && bus.mem_gnt));
    chk("dm_gnt", 32'(bus.dm_gnt), 32'(live && !accepted && cur.dm && bus.mem_gnt));
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(live && accepted && !cur.dm && bus.mem_rvalid));
    chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(live && accepted && cur.dm && bus.mem_rvalid));
    if (live && accepted && bus.mem_rvalid && !cur.we)
      chk("rdata", 32'(cur.dm ? bus.dm_rdata : bus.if_rdata), 32'(bus.mem_rdata));
    if_done = bus.if_gnt;
    dm_done = bus.dm_gnt;
    if_gnts += int'(bus.if_gnt);
    dm_gnts += int'(bus.dm_gnt);
`ifdef MEM_ARB_STARVE_GUARD_EN
    starved = losses >= DEF_STARVE_LIMIT;
`else
    starved = 1'b0;
`endif
    if (!live) begin
      if (bus.if_req || bus.dm_req) begin
        cur.dm    = bus.dm_req && !(bus.if_req && starved);
        cur.we    = cur.dm && bus.dm_we;
        cur.addr  = cur.dm ? bus.dm_addr : bus.if_addr;
        cur.wdata = bus.dm_wdata;
        losses    = cur.dm ? losses + int'(bus.if_req) : 0;
        live      = 1'b1;
        accepted  = 1'b0;
      end
    end else if (!accepted) accepted = bus.mem_gnt;
    else live = !bus.mem_rvalid;
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      body();
    end
  endtask
  task automatic reset_now();
    @(negedge clk_i);
    #2;
    rst_i          = 1'b0;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("rst_dm_gnt", 32'(bus.dm_gnt), 32'd0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
    live     = 1'b0;
    accepted = 1'b0;
    losses   = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    body();
  endtask
  task automatic knobs(input int unsigned a, input int unsigned b, input int unsigned c, input int unsigned d);
    p_if  = a;
    p_dm  = b;
    p_gnt = c;
    p_rv  = d;
  endtask
  initial begin
    int n;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.dm_req     = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_addr    = '0;
    bus.dm_wdata   = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    live = 1'b0; accepted = 1'b0; losses = 0; if_done = 1'b0; dm_done = 1'b0;
    knobs(0, 0, 0, 0);
    reset_now();
    knobs(100, 0, 100, 100);
    step(15);
    knobs(0, 0, 100, 100);
    step(10);
    if_gnts = 0;
    dm_gnts = 0;
    knobs(100, 100, 100, 100);
    step(60);
    chk("sat_if_gnts", 32'(if_gnts), 32'(SAT_IF));
    chk("sat_dm_gnts", 32'(dm_gnts), 32'(SAT_DM));
    knobs(50, 50, 50, 50);
    step(500);
    knobs(60, 60, 100, 0);
    n = 0;
    while (!(live && accepted) && n < 50) begin
      step(1);
      n++;
    end
    if (!(live && accepted)) chk("reach_resp", 32'd0, 32'd1);
    reset_now();
    knobs(60, 60, 0, 100);
    step(3);
    knobs(40, 40, 30, 30);
    step(300);
    knobs(0, 0, 100, 100);
    step(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
